// File: rtl/psk_pkg.sv
// Shared definitions for the PSK symbol unpacker: mode codes, default DAC amplitudes,
// FSM state type and the bit-to-amplitude helper.
package psk_pkg;

  localparam logic [1:0] MODE_BPSK = 2'd0;
  localparam logic [1:0] MODE_QPSK = 2'd1;
  localparam logic [1:0] MODE_RAW2 = 2'd2;

  // +/-80% of full scale
  localparam logic [15:0] DEF_AMP_ONE  = 16'h6665;
  localparam logic [15:0] DEF_AMP_ZERO = 16'h999B;

  typedef enum logic {
    StEmpty,
    StFull
  } unpack_state_e;

  function automatic logic [15:0] bit_to_amp(input logic b, input logic [15:0] amp_one,
                                             input logic [15:0] amp_zero);
    return b ? amp_one : amp_zero;
  endfunction

endpackage

// File: rtl/psk_symbol_mapper.sv
// Combinational symbol mapper: {mode, b1, b0} -> {I, Q} DAC codes or legacy raw 2-bit word.
// In BPSK only b1 is meaningful.
module psk_symbol_mapper
  import psk_pkg::*;
#(
  parameter logic [15:0] AMP_ONE  = DEF_AMP_ONE,
  parameter logic [15:0] AMP_ZERO = DEF_AMP_ZERO
) (
  input  logic [1:0]  mode,
  input  logic        b1,
  input  logic        b0,
  output logic [31:0] tdata
);

  always_comb begin
    tdata = '0;
    case (mode)
      MODE_BPSK: tdata = {bit_to_amp(b1, AMP_ONE, AMP_ZERO), 16'h0000};
      MODE_RAW2: tdata = {30'b0, b1, b0};
      // QPSK and the reserved code
      default:   tdata = {bit_to_amp(b1, AMP_ONE, AMP_ZERO), bit_to_amp(b0, AMP_ONE, AMP_ZERO)};
    endcase
  end

endmodule

// File: rtl/psk_symbol_unpacker.sv
// Unpacks IN_W-bit words into one BPSK/QPSK/RAW2 symbol per output beat, MSB first,
// with zero-bubble reload on the last symbol and tlast carried to the final symbol.
module psk_symbol_unpacker
  import psk_pkg::*;
#(
  parameter int unsigned IN_W     = 32,
  parameter logic [15:0] AMP_ONE  = DEF_AMP_ONE,
  parameter logic [15:0] AMP_ZERO = DEF_AMP_ZERO
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      mode,
  input  logic [IN_W-1:0] in_tdata,
  input  logic            in_tlast,
  input  logic            in_tvalid,
  output logic            in_tready,
  output logic [31:0]     out_tdata,
  output logic            out_tlast,
  output logic            out_tvalid,
  input  logic            out_tready
);

  localparam int unsigned CW = $clog2(IN_W);

  unpack_state_e   state_q;
  logic [IN_W-1:0] word_q;
  logic            tlast_q;
  logic [1:0]      mode_q;
  logic [CW-1:0]   cnt_q;

  logic          two_bit;
  logic [CW-1:0] last_idx;
  logic [CW-1:0] step;
  logic [CW-1:0] idx_hi;
  logic [CW-1:0] idx_lo;
  logic          last_sym;
  logic          out_hs;
  logic          accept;
  logic          b1;
  logic          b0;

  always_comb begin
    two_bit  = (mode_q != MODE_BPSK);
    last_idx = two_bit ? CW'(IN_W / 2 - 1) : CW'(IN_W - 1);
    // In two-bit modes cnt_q < IN_W/2, so doubling it cannot overflow CW bits
    step     = two_bit ? (cnt_q << 1) : cnt_q;
    idx_hi   = CW'(IN_W - 1) - step;
    idx_lo   = idx_hi - CW'(1);
    b1       = word_q[idx_hi];
    b0       = two_bit ? word_q[idx_lo] : 1'b0;
    last_sym = (cnt_q == last_idx);
  end

  assign out_tvalid = (state_q == StFull);
  assign out_hs     = out_tvalid & out_tready;
  assign in_tready  = (state_q == StEmpty) | (out_hs & last_sym);
  assign accept     = in_tvalid & in_tready;
  assign out_tlast  = out_tvalid & tlast_q & last_sym;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      word_q  <= '0;
      tlast_q <= 1'b0;
      mode_q  <= MODE_BPSK;
      cnt_q   <= '0;
    end else if (accept) begin
      state_q <= StFull;
      word_q  <= in_tdata;
      tlast_q <= in_tlast;
      mode_q  <= mode;
      cnt_q   <= '0;
    end else if (out_hs) begin
      if (last_sym) begin
        state_q <= StEmpty;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  psk_symbol_mapper #(
    .AMP_ONE (AMP_ONE),
    .AMP_ZERO(AMP_ZERO)
  ) u_mapper (
    .mode (mode_q),
    .b1   (b1),
    .b0   (b0),
    .tdata(out_tdata)
  );

endmodule

// File: tb/tb_psk_symbol_unpacker.sv
// Self-checking bench for psk_symbol_unpacker: vector table, back-to-back streaming,
// random stalls against a symbol-list reference model, and mid-word reset.
module tb_psk_symbol_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  mode;
  logic [31:0] in_tdata;
  logic        in_tlast;
  logic        in_tvalid;
  logic        in_tready;
  logic [31:0] out_tdata;
  logic        out_tlast;
  logic        out_tvalid;
  logic        out_tready;

  always #5 clk = ~clk;

  psk_symbol_unpacker #(.IN_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_tdata  (in_tdata),
    .in_tlast  (in_tlast),
    .in_tvalid (in_tvalid),
    .in_tready (in_tready),
    .out_tdata (out_tdata),
    .out_tlast (out_tlast),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: symbol k of a word straight from the mapping rules
  function automatic logic [31:0] ref_sym(input logic [1:0] m, input logic [31:0] w,
                                          input int k);
    logic [31:0] bitv;
    logic [31:0] pair;
    if (m == 2'd0) begin
      bitv = (w >> (31 - k)) & 32'd1;
      return {(bitv != 0) ? 16'h6665 : 16'h999B, 16'h0000};
    end
    pair = (w >> (30 - 2 * k)) & 32'd3;
    if (m == 2'd2) return pair;
    return {pair[1] ? 16'h6665 : 16'h999B, pair[0] ? 16'h6665 : 16'h999B};
  endfunction

  function automatic int nsym(input logic [1:0] m);
    return (m == 2'd0) ? 32 : 16;
  endfunction

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] cap_d[$];
  logic        cap_l[$];
  int          hs_total = 0;

  // Monitor: scoreboard, beat capture, stall stability
  initial begin
    logic        held;
    logic [31:0] held_d;
    logic        held_l;
    beat_t       e;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        held = 1'b0;
      end else begin
        if (held && out_tvalid) begin
          check("stall_data_stable", out_tdata, held_d);
          check("stall_last_stable", {31'b0, out_tlast}, {31'b0, held_l});
        end
        held   = out_tvalid && !out_tready;
        held_d = out_tdata;
        held_l = out_tlast;
        if (out_tvalid && out_tready) begin
          cap_d.push_back(out_tdata);
          cap_l.push_back(out_tlast);
          hs_total++;
          if (exp_q.size() == 0) begin
            check("sb_unexpected_beat", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("sb_data", out_tdata, e.data);
            check("sb_last", {31'b0, out_tlast}, {31'b0, e.last});
          end
        end
        if (in_tvalid && in_tready) begin
          for (int k = 0; k < nsym(mode); k++) begin
            e.data = ref_sym(mode, in_tdata, k);
            e.last = in_tlast && (k == nsym(mode) - 1);
            exp_q.push_back(e);
          end
        end
      end
    end
  end

  task automatic drive_word(input logic [1:0] m, input logic [31:0] w, input logic l);
    logic ok;
    int   n;
    mode      = m;
    in_tdata  = w;
    in_tlast  = l;
    in_tvalid = 1'b1;
    ok        = 1'b0;
    n         = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) check("accept_timeout", 32'd1, 32'd0);
    in_tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (out_tvalid && n < 400);
    if (out_tvalid) check("idle_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] word;
    logic        tlast;
    int          beat;
    logic [31:0] exp_data;
    logic        exp_last;
    int          exp_n;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [31:0] w3[3];
    int          hs, run, maxrun, np, wi, sent, n;
    int          pulses[2];
    logic        acc;

    vecs.push_back('{2'd1, 32'hE4E4_E4E4, 1'b0, 0,  32'h6665_6665, 1'b0, 16});
    vecs.push_back('{2'd1, 32'hE4E4_E4E4, 1'b0, 1,  32'h6665_999B, 1'b0, 16});
    vecs.push_back('{2'd1, 32'hE4E4_E4E4, 1'b0, 2,  32'h999B_6665, 1'b0, 16});
    vecs.push_back('{2'd1, 32'hE4E4_E4E4, 1'b0, 3,  32'h999B_999B, 1'b0, 16});
    vecs.push_back('{2'd1, 32'hE4E4_E4E4, 1'b0, 15, 32'h999B_999B, 1'b0, 16});
    vecs.push_back('{2'd2, 32'h8000_0001, 1'b0, 0,  32'h0000_0002, 1'b0, 16});
    vecs.push_back('{2'd2, 32'h8000_0001, 1'b0, 1,  32'h0000_0000, 1'b0, 16});
    vecs.push_back('{2'd2, 32'h8000_0001, 1'b0, 14, 32'h0000_0000, 1'b0, 16});
    vecs.push_back('{2'd2, 32'h8000_0001, 1'b1, 15, 32'h0000_0001, 1'b1, 16});
    vecs.push_back('{2'd0, 32'hAAAA_AAAA, 1'b1, 0,  32'h6665_0000, 1'b0, 32});
    vecs.push_back('{2'd0, 32'hAAAA_AAAA, 1'b1, 1,  32'h999B_0000, 1'b0, 32});
    vecs.push_back('{2'd0, 32'hAAAA_AAAA, 1'b1, 30, 32'h6665_0000, 1'b0, 32});
    vecs.push_back('{2'd0, 32'hAAAA_AAAA, 1'b1, 31, 32'h999B_0000, 1'b1, 32});
    vecs.push_back('{2'd3, 32'hE4E4_E4E4, 1'b0, 1,  32'h6665_999B, 1'b0, 16});

    reset      = 1'b1;
    mode       = 2'd1;
    in_tdata   = '0;
    in_tlast   = 1'b0;
    in_tvalid  = 1'b0;
    out_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_tvalid", {31'b0, out_tvalid}, 32'd0);
    check("rst_out_tlast", {31'b0, out_tlast}, 32'd0);
    check("rst_in_tready", {31'b0, in_tready}, 32'd1);
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      cap_d.delete();
      cap_l.delete();
      drive_word(vecs[i].mode, vecs[i].word, vecs[i].tlast);
      wait_idle();
      check($sformatf("vec%0d_count", i), cap_d.size(), vecs[i].exp_n);
      if (cap_d.size() > vecs[i].beat) begin
        check($sformatf("vec%0d_beat%0d_data", i, vecs[i].beat), cap_d[vecs[i].beat],
              vecs[i].exp_data);
        check($sformatf("vec%0d_beat%0d_last", i, vecs[i].beat), {31'b0, cap_l[vecs[i].beat]},
              {31'b0, vecs[i].exp_last});
      end
    end

    // Three back-to-back QPSK words with a permanently ready sink
    w3[0] = 32'h1234_5678;
    w3[1] = 32'h9ABC_DEF0;
    w3[2] = 32'h0F0F_A5A5;
    wi = 0; hs = 0; run = 0; maxrun = 0; np = 0;
    pulses[0] = -1;
    pulses[1] = -1;
    mode = 2'd1; in_tlast = 1'b0; in_tdata = w3[0]; in_tvalid = 1'b1; out_tready = 1'b1;
    for (int cyc = 0; cyc < 120 && !(wi == 3 && hs == 48); cyc++) begin
      @(negedge clk);
      acc = in_tvalid && in_tready;
      if (out_tvalid) begin
        run++;
        if (acc && np < 2) begin
          pulses[np] = hs;
          np++;
        end
        hs++;
      end else begin
        run = 0;
      end
      if (run > maxrun) maxrun = run;
      @(posedge clk);
      #1;
      if (acc) begin
        wi++;
        if (wi == 3) in_tvalid = 1'b0;
        else in_tdata = w3[wi];
      end
    end
    check("b2b_beats", hs, 48);
    check("b2b_no_gap", maxrun, 48);
    check("b2b_ready_pulse0", pulses[0], 15);
    check("b2b_ready_pulse1", pulses[1], 31);
    wait_idle();

    // Random words, modes and sink stalls against the scoreboard
    sent = 0;
    n    = 0;
    in_tvalid = 1'b0;
    while ((sent < 20 || exp_q.size() != 0 || out_tvalid) && n < 5000) begin
      @(negedge clk);
      acc = in_tvalid && in_tready;
      if (acc) sent++;
      @(posedge clk);
      #1;
      n++;
      out_tready = 1'($urandom % 2);
      if (!in_tvalid || acc) begin
        if (sent < 20 && ($urandom % 2) == 1) begin
          in_tvalid = 1'b1;
          in_tdata  = $urandom;
          mode      = 2'($urandom % 4);
          in_tlast  = 1'($urandom % 2);
        end else begin
          in_tvalid = 1'b0;
        end
      end
    end
    check("rand_words_sent", sent, 20);
    check("rand_sb_drained", exp_q.size(), 0);
    out_tready = 1'b1;

    // Reset while beat 5 of a word is presented
    drive_word(2'd1, 32'hC3C3_3C3C, 1'b1);
    n = hs_total;
    for (int c = 0; c < 50 && hs_total - n < 5; c++) begin
      @(posedge clk);
      #1;
    end
    check("rstmid_reached_beat5", hs_total - n, 5);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rstmid_out_tvalid", {31'b0, out_tvalid}, 32'd0);
    check("rstmid_in_tready", {31'b0, in_tready}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cap_d.delete();
    cap_l.delete();
    drive_word(2'd1, 32'h5A5A_0FF0, 1'b0);
    wait_idle();
    check("rstmid_next_count", cap_d.size(), 16);
    if (cap_d.size() > 0) check("rstmid_next_sym0", cap_d[0], ref_sym(2'd1, 32'h5A5A_0FF0, 0));
    check("final_sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
